tomas_issue_unit: RTL and testbench

- Issue stage directly downstream of the 8-entry instruction queue in the Tomasulo core.
- Pops 16-bit instructions from the queue and decodes them.
- Allocates a free reservation station of the right class, renames the destination through an internal register status table, and dispatches operands or tags to the stations.
- Snoops the CDB to clear the status table and to forward results in the issue cycle.

---
 rtl/tomas_issue_unit.sv | 195 +++++++++++++++++++
 tb/tb_tomas_issue_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomas_issue_unit.sv
// Tomasulo issue stage: pops instructions from the instruction queue, picks a
// free reservation station, renames rd through the register status table and
// dispatches operand values or producer tags, forwarding same-cycle CDB results.
module tomas_issue_unit #(
  parameter int N_ADD = 3,
  parameter int N_MUL = 2,
  parameter int TAG_W = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iq_valid,
  input  logic [15:0]            iq_data,
  output logic                   iq_pop,
  output logic [2:0]             rf_addr_a,
  output logic [2:0]             rf_addr_b,
  input  logic [15:0]            rf_data_a,
  input  logic [15:0]            rf_data_b,
  input  logic [N_ADD+N_MUL-1:0] rs_busy,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [15:0]            cdb_data,
  output logic                   issue_valid,
  output logic [TAG_W-1:0]       issue_tag,
  output logic [1:0]             issue_op,
  output logic [15:0]            issue_vj,
  output logic [15:0]            issue_vk,
  output logic [TAG_W-1:0]       issue_qj,
  output logic [TAG_W-1:0]       issue_qk,
  output logic                   illegal,
  output logic [15:0]            issued_cnt,
  output logic [15:0]            stall_cnt
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t            state, state_next;
  logic [15:0]       ir;
  logic [TAG_W-1:0]  status_tab [8];

  logic [3:0]        opcode;
  logic [2:0]        rd;
  logic              is_add, is_mul, is_nop;
  logic              found;
  logic [TAG_W-1:0]  sel_tag;
  logic [TAG_W-1:0]  tag_j, tag_k;
  logic [15:0]       vj_next, vk_next;
  logic [TAG_W-1:0]  qj_next, qk_next;
  logic              pop_req, do_issue, do_illegal, do_stall;
  logic              unused_ir_bits;

  assign opcode         = ir[15:12];
  assign rd             = ir[11:9];
  assign rf_addr_a      = ir[8:6];
  assign rf_addr_b      = ir[5:3];
  assign unused_ir_bits = ^ir[2:0];
  assign tag_j          = status_tab[ir[8:6]];
  assign tag_k          = status_tab[ir[5:3]];
  assign iq_pop         = pop_req & reset_n;

  // Decode the held instruction into its station class
  always_comb begin
    is_add = (opcode == 4'd0) || (opcode == 4'd1);
    is_mul = (opcode == 4'd2);
    is_nop = (opcode == 4'd15);
  end

  // Pick the lowest-index non-busy station of the instruction's class
  always_comb begin
    found   = 1'b0;
    sel_tag = '0;
    if (is_add) begin
      for (int i = 0; i < N_ADD; i++) begin
        if (!found && !rs_busy[i]) begin
          found   = 1'b1;
          sel_tag = TAG_W'(i + 1);
        end
      end
    end else if (is_mul) begin
      for (int i = 0; i < N_MUL; i++) begin
        if (!found && !rs_busy[N_ADD + i]) begin
          found   = 1'b1;
          sel_tag = TAG_W'(N_ADD + i + 1);
        end
      end
    end
  end

  // Resolve each source to a value or a producer tag, forwarding a matching CDB result
  always_comb begin
    vj_next = '0;
    qj_next = '0;
    vk_next = '0;
    qk_next = '0;
    if (tag_j == '0)
      vj_next = rf_data_a;
    else if (cdb_valid && cdb_tag == tag_j)
      vj_next = cdb_data;
    else
      qj_next = tag_j;
    if (tag_k == '0)
      vk_next = rf_data_b;
    else if (cdb_valid && cdb_tag == tag_k)
      vk_next = cdb_data;
    else
      qk_next = tag_k;
  end

  // Next-state and per-cycle control: pop, issue, drop or stall
  always_comb begin
    state_next = state;
    pop_req    = 1'b0;
    do_issue   = 1'b0;
    do_illegal = 1'b0;
    do_stall   = 1'b0;
    case (state)
      EMPTY: begin
        if (iq_valid) begin
          pop_req    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (is_add || is_mul) begin
          if (found) begin
            do_issue   = 1'b1;
            pop_req    = iq_valid;
            state_next = iq_valid ? HOLD : EMPTY;
          end else begin
            do_stall = 1'b1;
          end
        end else begin
          do_illegal = !is_nop;
          pop_req    = iq_valid;
          state_next = iq_valid ? HOLD : EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register and instruction register, loaded on every pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (pop_req)
        ir <= iq_data;
    end
  end

  // Registered dispatch outputs, the illegal pulse and the wrapping counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid <= 1'b0;
      issue_tag   <= '0;
      issue_op    <= '0;
      issue_vj    <= '0;
      issue_vk    <= '0;
      issue_qj    <= '0;
      issue_qk    <= '0;
      illegal     <= 1'b0;
      issued_cnt  <= '0;
      stall_cnt   <= '0;
    end else begin
      issue_valid <= do_issue;
      illegal     <= do_illegal;
      issue_tag   <= do_issue ? sel_tag : '0;
      issue_op    <= do_issue ? opcode[1:0] : 2'b00;
      issue_vj    <= do_issue ? vj_next : 16'd0;
      issue_vk    <= do_issue ? vk_next : 16'd0;
      issue_qj    <= do_issue ? qj_next : '0;
      issue_qk    <= do_issue ? qk_next : '0;
      issued_cnt  <= issued_cnt + {15'd0, do_issue};
      stall_cnt   <= stall_cnt + {15'd0, do_stall};
    end
  end

  // Status table: CDB clears matching entries, a new issue to rd overrides that clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < 8; e++)
        status_tab[e] <= '0;
    end else begin
      for (int e = 0; e < 8; e++) begin
        if (cdb_valid && cdb_tag != '0 && status_tab[e] == cdb_tag)
          status_tab[e] <= '0;
      end
      if (do_issue)
        status_tab[rd] <= sel_tag;
    end
  end

endmodule

// File: tb/tb_tomas_issue_unit.sv
// Self-checking bench for tomas_issue_unit: directed scenarios followed by a
// randomized run against an instruction-level reference model.
module tb_tomas_issue_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        iq_valid = 1'b0;
  logic [15:0] iq_data = '0;
  logic        iq_pop;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic [4:0]  rs_busy = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        issue_valid;
  logic [2:0]  issue_tag;
  logic [1:0]  issue_op;
  logic [15:0] issue_vj, issue_vk;
  logic [2:0]  issue_qj, issue_qk;
  logic        illegal;
  logic [15:0] issued_cnt, stall_cnt;

  logic [15:0] regfile [8];
  int errors = 0;
  int checks = 0;

  assign rf_data_a = regfile[rf_addr_a];
  assign rf_data_b = regfile[rf_addr_b];

  always #5 clock = ~clock;

  tomas_issue_unit #(.N_ADD(3), .N_MUL(2), .TAG_W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .iq_valid(iq_valid), .iq_data(iq_data), .iq_pop(iq_pop),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rs_busy(rs_busy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .illegal(illegal), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    iq_valid  = 1'b0;
    iq_data   = '0;
    rs_busy   = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    for (int r = 0; r < 8; r++) regfile[r] = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({iq_pop, issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
         illegal, issued_cnt, stall_cnt, rf_addr_a, rf_addr_b} !== '0)
      begin errors++; $display("[TB] FAIL reset_outputs: got pop=%b iv=%b cnt=%h/%h required all zero",
                               iq_pop, issue_valid, issued_cnt, stall_cnt); end
    for (int e = 0; e < 8; e++) begin
      checks++;
      if (dut.status_tab[e] !== 3'd0)
        begin errors++; $display("[TB] FAIL reset_status[%0d]: got %0d required 0", e, dut.status_tab[e]); end
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({iq_pop, issue_valid} !== 2'b00)
      begin errors++; $display("[TB] FAIL idle_empty: got pop=%b iv=%b required 0 0", iq_pop, issue_valid); end
    iq_valid = 1'b1;
    iq_data  = 16'h0298;
    rs_busy  = 5'b11111;
    tick();
    iq_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd2)
      begin errors++; $display("[TB] FAIL pre_reset_stall: got %0d required 2", stall_cnt); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut.ir !== 16'h0000)
      begin errors++; $display("[TB] FAIL reset_clears_ir: got %h required 0000", dut.ir); end
    checks++;
    if (stall_cnt !== 16'd0)
      begin errors++; $display("[TB] FAIL reset_clears_stall: got %0d required 0", stall_cnt); end
    tick();
    reset_n = 1'b1;
    rs_busy = '0;
    tick();
    tick();
    checks++;
    if (issue_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL discarded_ir: got iv=%b required 0", issue_valid); end
    iq_valid = 1'b1;
    iq_data  = 16'hF000;
    #1;
    checks++;
    if (iq_pop !== 1'b1)
      begin errors++; $display("[TB] FAIL empty_after_reset: got pop=%b required 1", iq_pop); end
    tick();
    iq_valid = 1'b0;
    tick();
  endtask

  task automatic test_add_mul();
    do_reset();
    regfile[2] = 16'd5;
    regfile[3] = 16'd7;
    iq_valid = 1'b1;
    iq_data  = 16'h0298;
    #1;
    checks++;
    if (iq_pop !== 1'b1)
      begin errors++; $display("[TB] FAIL add_pop: got %b required 1", iq_pop); end
    tick();
    checks++;
    if ({issue_valid, rf_addr_a, rf_addr_b} !== {1'b0, 3'd2, 3'd3})
      begin errors++; $display("[TB] FAIL add_hold: got iv=%b a=%0d b=%0d required 0 2 3",
                               issue_valid, rf_addr_a, rf_addr_b); end
    iq_data = 16'h2848;
    #1;
    checks++;
    if (iq_pop !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_pop: got %b required 1", iq_pop); end
    tick();
    checks++;
    if ({issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk} !==
        {1'b1, 3'd1, 2'b00, 16'd5, 16'd7, 3'd0, 3'd0})
      begin errors++; $display("[TB] FAIL add_issue: got v=%b t=%0d op=%b vj=%h vk=%h qj=%0d qk=%0d required 1 1 00 0005 0007 0 0",
                               issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk); end
    checks++;
    if (dut.status_tab[1] !== 3'd1)
      begin errors++; $display("[TB] FAIL add_rename: got %0d required 1", dut.status_tab[1]); end
    tick();
    checks++;
    if ({issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk} !==
        {1'b1, 3'd4, 2'b10, 16'd0, 16'd0, 3'd1, 3'd1})
      begin errors++; $display("[TB] FAIL mul_wait: got v=%b t=%0d op=%b vj=%h vk=%h qj=%0d qk=%0d required 1 4 10 0 0 1 1",
                               issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk); end
    iq_valid  = 1'b0;
    rs_busy   = 5'b01001;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd1;
    cdb_data  = 16'h000C;
    tick();
    cdb_valid = 1'b0;
    checks++;
    if ({issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk} !==
        {1'b1, 3'd5, 2'b10, 16'h000C, 16'h000C, 3'd0, 3'd0})
      begin errors++; $display("[TB] FAIL mul_forward: got v=%b t=%0d vj=%h vk=%h qj=%0d qk=%0d required 1 5 000c 000c 0 0",
                               issue_valid, issue_tag, issue_vj, issue_vk, issue_qj, issue_qk); end
    checks++;
    if ({dut.status_tab[1], dut.status_tab[4], issued_cnt} !== {3'd0, 3'd5, 16'd3})
      begin errors++; $display("[TB] FAIL mul_status: got s1=%0d s4=%0d cnt=%0d required 0 5 3",
                               dut.status_tab[1], dut.status_tab[4], issued_cnt); end
    rs_busy  = '0;
    iq_valid = 1'b1;
    iq_data  = 16'h1298;
    tick();
    checks++;
    if (issue_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL strobe_one_cycle: got %b required 0", issue_valid); end
    iq_valid = 1'b0;
    tick();
    checks++;
    if ({issue_valid, issue_tag, issue_op, issue_vj} !== {1'b1, 3'd1, 2'b01, 16'd5})
      begin errors++; $display("[TB] FAIL sub_issue: got v=%b t=%0d op=%b vj=%h required 1 1 01 0005",
                               issue_valid, issue_tag, issue_op, issue_vj); end
  endtask

  task automatic test_stall();
    do_reset();
    rs_busy  = 5'b00111;
    iq_valid = 1'b1;
    iq_data  = 16'h0298;
    tick();
    iq_data  = 16'hF000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({iq_pop, issue_valid} !== 2'b00)
        begin errors++; $display("[TB] FAIL stall_cycle%0d: got pop=%b iv=%b required 0 0", c, iq_pop, issue_valid); end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd4)
      begin errors++; $display("[TB] FAIL stall_count: got %0d required 4", stall_cnt); end
    rs_busy = 5'b00101;
    #1;
    checks++;
    if (iq_pop !== 1'b1)
      begin errors++; $display("[TB] FAIL stall_release_pop: got %b required 1", iq_pop); end
    tick();
    iq_valid = 1'b0;
    checks++;
    if ({issue_valid, issue_tag, stall_cnt} !== {1'b1, 3'd2, 16'd4})
      begin errors++; $display("[TB] FAIL stall_release: got v=%b t=%0d stall=%0d required 1 2 4",
                               issue_valid, issue_tag, stall_cnt); end
    tick();
  endtask

  task automatic test_illegal();
    int pops;
    do_reset();
    pops = 0;
    iq_valid = 1'b1;
    iq_data  = 16'h7000;
    #1;
    if (iq_pop) pops++;
    tick();
    iq_data = 16'hF000;
    #1;
    if (iq_pop) pops++;
    tick();
    iq_valid = 1'b0;
    checks++;
    if ({illegal, issue_valid} !== 2'b10)
      begin errors++; $display("[TB] FAIL illegal_pulse: got ill=%b iv=%b required 1 0", illegal, issue_valid); end
    tick();
    checks++;
    if ({illegal, issue_valid, issued_cnt} !== {2'b00, 16'd0})
      begin errors++; $display("[TB] FAIL nop_retire: got ill=%b iv=%b cnt=%0d required 0 0 0",
                               illegal, issue_valid, issued_cnt); end
    checks++;
    if (pops !== 2)
      begin errors++; $display("[TB] FAIL illegal_pops: got %0d required 2", pops); end
    iq_valid = 1'b1;
    #1;
    checks++;
    if (iq_pop !== 1'b1)
      begin errors++; $display("[TB] FAIL nop_to_empty: got pop=%b required 1", iq_pop); end
    tick();
    iq_valid = 1'b0;
    tick();
  endtask

  task automatic test_issue_vs_cdb();
    do_reset();
    regfile[2] = 16'h0022;
    iq_valid = 1'b1;
    iq_data  = 16'h0298;
    tick();
    tick();
    cdb_valid = 1'b1;
    cdb_tag   = 3'd1;
    cdb_data  = 16'h1111;
    iq_data   = 16'h0250;
    tick();
    cdb_valid = 1'b0;
    iq_valid  = 1'b0;
    rs_busy   = 5'b00001;
    checks++;
    if ({issue_valid, issue_tag, dut.status_tab[1]} !== {1'b1, 3'd1, 3'd1})
      begin errors++; $display("[TB] FAIL issue_beats_cdb: got v=%b t=%0d s1=%0d required 1 1 1",
                               issue_valid, issue_tag, dut.status_tab[1]); end
    tick();
    checks++;
    if ({issue_valid, issue_tag, issue_qj, issue_vj, issue_qk, issue_vk, dut.status_tab[1]} !==
        {1'b1, 3'd2, 3'd1, 16'd0, 3'd0, 16'h0022, 3'd2})
      begin errors++; $display("[TB] FAIL self_dependency: got t=%0d qj=%0d vj=%h qk=%0d vk=%h s1=%0d required 2 1 0 0 0022 2",
                               issue_tag, issue_qj, issue_vj, issue_qk, issue_vk, dut.status_tab[1]); end
    rs_busy = '0;
    tick();
  endtask

  function automatic logic [15:0] rand_instr();
    int sel;
    logic [3:0] opc;
    sel = $urandom_range(0, 9);
    if (sel < 3)       opc = 4'd0;
    else if (sel < 5)  opc = 4'd1;
    else if (sel < 8)  opc = 4'd2;
    else if (sel == 8) opc = 4'd15;
    else               opc = 4'($urandom_range(3, 14));
    return {opc, 12'($urandom)};
  endfunction

  // A source reads the table as it stood before this cycle's updates
  function automatic void resolve(input logic [2:0] t, input logic [15:0] rf, input logic cv,
                                  input logic [2:0] ct, input logic [15:0] cd,
                                  output logic [15:0] v, output logic [2:0] q);
    if (t == 0)                 begin v = rf; q = 0; end
    else if (cv && ct == t)     begin v = cd; q = 0; end
    else                        begin v = 0;  q = t; end
  endfunction

  task automatic test_random();
    logic [15:0] q[$];
    logic        m_has;
    logic [15:0] m_ir;
    logic [2:0]  m_st [8];
    int          m_iss, m_stl;
    logic [3:0]  opc;
    logic        alu, free, e_valid, e_ill, e_pop;
    logic [2:0]  e_tag, e_qj, e_qk;
    logic [15:0] e_vj, e_vk;
    int          first, n;
    do_reset();
    m_has = 0; m_ir = 0; m_iss = 0; m_stl = 0;
    for (int e = 0; e < 8; e++) m_st[e] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      while (q.size() < 4) q.push_back(rand_instr());
      iq_valid  = ($urandom_range(0, 3) != 0);
      iq_data   = q[0];
      rs_busy   = 5'($urandom);
      if ($urandom_range(0, 1) == 1) rs_busy = rs_busy & 5'($urandom);
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 3'($urandom);
      cdb_data  = 16'($urandom);
      for (int r = 0; r < 8; r++) regfile[r] = 16'($urandom);
      opc   = m_ir[15:12];
      alu   = m_has && (opc <= 4'd2);
      first = (opc == 4'd2) ? 3 : 0;
      n     = (opc == 4'd2) ? 2 : 3;
      free  = 0;
      e_tag = 0;
      if (alu)
        for (int k = 0; k < n; k++)
          if (!free && !rs_busy[first + k]) begin free = 1; e_tag = 3'(first + k + 1); end
      e_valid = alu && free;
      e_ill   = m_has && !alu && (opc != 4'd15);
      e_pop   = iq_valid && (!m_has || !alu || free);
      resolve(m_st[m_ir[8:6]], regfile[m_ir[8:6]], cdb_valid, cdb_tag, cdb_data, e_vj, e_qj);
      resolve(m_st[m_ir[5:3]], regfile[m_ir[5:3]], cdb_valid, cdb_tag, cdb_data, e_vk, e_qk);
      if (!e_valid) begin e_vj = 0; e_vk = 0; e_qj = 0; e_qk = 0; end
      #1;
      checks++;
      if (iq_pop !== e_pop)
        begin errors++; $display("[TB] FAIL rand_pop cyc%0d: got %b required %b", cyc, iq_pop, e_pop); end
      tick();
      checks++;
      if ({issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, illegal} !==
          {e_valid, e_tag, e_valid ? opc[1:0] : 2'b00, e_vj, e_vk, e_qj, e_qk, e_ill})
        begin errors++; $display("[TB] FAIL rand_issue cyc%0d: got v=%b t=%0d op=%b vj=%h vk=%h qj=%0d qk=%0d ill=%b required %b %0d %b %h %h %0d %0d %b",
                                 cyc, issue_valid, issue_tag, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, illegal,
                                 e_valid, e_tag, e_valid ? opc[1:0] : 2'b00, e_vj, e_vk, e_qj, e_qk, e_ill); end
      for (int e = 0; e < 8; e++)
        if (cdb_valid && cdb_tag != 0 && m_st[e] == cdb_tag) m_st[e] = 0;
      if (e_valid) begin m_st[m_ir[11:9]] = e_tag; m_iss++; end
      if (alu && !free) m_stl++;
      checks++;
      if ({issued_cnt, stall_cnt} !== {16'(m_iss), 16'(m_stl)})
        begin errors++; $display("[TB] FAIL rand_counters cyc%0d: got %0d/%0d required %0d/%0d",
                                 cyc, issued_cnt, stall_cnt, m_iss, m_stl); end
      if (e_pop) begin m_ir = q.pop_front(); m_has = 1; end
      else if (m_has && !(alu && !free)) m_has = 0;
    end
    iq_valid  = 1'b0;
    cdb_valid = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_add_mul();
    test_stall();
    test_illegal();
    test_issue_vs_cdb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
